// File: rtl/lsu_mem_requester.sv
// rtl/lsu_mem_requester.sv - single-outstanding load/store requester driving the data-memory strobe port
// Optional LSU_MISALIGN_TRAP_EN turns misaligned halfword/word requests into error completions.
module lsu_mem_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_write_data_q;
  logic        mem_memread_q;
  logic        mem_memwrite_q;
  logic [3:0]  mem_sign_mask_q;
  logic        write_q;
  logic        err_pend_q;
  logic        seen_stall_q;
  logic [7:0]  tmo_cnt_q;

  logic [3:0]  mask_d;
  logic        misalign_d;
  logic        bad_d;
  logic        tmo_hit_d;

  always_comb begin
    mask_d = {req_signed, 3'b111};
    case (req_size)
      2'b00:   mask_d[2:0] = 3'b001;
      2'b01:   mask_d[2:0] = 3'b011;
      default: mask_d[2:0] = 3'b111;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign_d = 1'b0;
`endif
    bad_d     = (req_size == 2'b11) || misalign_d;
    tmo_hit_d = ((tmo_cnt_q + 8'd1) == TMO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      req_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= 32'd0;
      rsp_err_q        <= 1'b0;
      mem_addr_q       <= 32'd0;
      mem_write_data_q <= 32'd0;
      mem_memread_q    <= 1'b0;
      mem_memwrite_q   <= 1'b0;
      mem_sign_mask_q  <= 4'd0;
      write_q          <= 1'b0;
      err_pend_q       <= 1'b0;
      seen_stall_q     <= 1'b0;
      tmo_cnt_q        <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Memory has no reset and may still finish a timed-out access; never overlap it.
          req_ready_q <= !mem_clk_stall;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            if (bad_d) begin
              err_pend_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              mem_addr_q       <= req_addr;
              mem_write_data_q <= req_wdata;
              mem_sign_mask_q  <= mask_d;
              mem_memread_q    <= !req_write;
              mem_memwrite_q   <= req_write;
              state_q          <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // Strobes must drop after one cycle or the idle memory starts a second access.
          mem_memread_q  <= 1'b0;
          mem_memwrite_q <= 1'b0;
          seen_stall_q   <= 1'b0;
          tmo_cnt_q      <= 8'd0;
          state_q        <= S_WAIT;
        end
        S_WAIT: begin
          tmo_cnt_q <= tmo_cnt_q + 8'd1;
          if (mem_clk_stall) seen_stall_q <= 1'b1;
          if (seen_stall_q && !mem_clk_stall) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= write_q ? 32'd0 : mem_read_data;
            state_q     <= S_RESP;
          end else if (tmo_hit_d) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 32'd0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_valid_q) begin
            rsp_valid_q      <= 1'b0;
            rsp_err_q        <= 1'b0;
            rsp_rdata_q      <= 32'd0;
            mem_addr_q       <= 32'd0;
            mem_write_data_q <= 32'd0;
            mem_sign_mask_q  <= 4'd0;
            err_pend_q       <= 1'b0;
            req_ready_q      <= !mem_clk_stall;
            state_q          <= S_IDLE;
          end else begin
            // Error taken straight from IDLE: pulse the response one cycle later.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_pend_q;
            rsp_rdata_q <= 32'd0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_memread    = mem_memread_q;
  assign mem_memwrite   = mem_memwrite_q;
  assign mem_sign_mask  = mem_sign_mask_q;

endmodule

// File: tb/tb_lsu_mem_requester.sv
// tb/tb_lsu_mem_requester.sv - directed checks of lsu_mem_requester against a two-cycle-stall memory model
module tb_lsu_mem_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'd0;
  logic        mem_clk_stall;

  logic        model_en = 1'b1;
  logic        model_stall = 1'b0;
  logic        tb_hold = 1'b0;
  int          stall_left = 0;

  int pass_cnt = 0;
  int total = 0;

  lsu_mem_requester #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  always #5 clk = ~clk;

  assign mem_clk_stall = model_stall | tb_hold;

  // Memory model: a strobe seen at edge E0 raises clk_stall from E1 to E3.
  always @(posedge clk) begin
    if (model_en && (mem_memread || mem_memwrite)) begin
      model_stall <= 1'b1;
      stall_left  <= 2;
    end else if (stall_left > 1) begin
      stall_left <= stall_left - 1;
    end else if (stall_left == 1) begin
      stall_left  <= 0;
      model_stall <= 1'b0;
    end
  end

  task automatic run_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [1:0] sz, input logic sg,
                            output int rsp_k, output logic [31:0] rdata, output logic err,
                            output int rd_n, output int wr_n, output logic [31:0] addr_s,
                            output logic [31:0] wdata_s, output logic [3:0] mask_s);
    int w;
    rsp_k = -1; rdata = 32'd0; err = 1'b0; rd_n = 0; wr_n = 0;
    addr_s = 32'd0; wdata_s = 32'd0; mask_s = 4'd0;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) begin
      rsp_k = -2;
      return;
    end
    req_write = wr; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    addr_s = mem_addr; wdata_s = mem_write_data; mask_s = mem_sign_mask;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      rd_n += int'(mem_memread);
      wr_n += int'(mem_memwrite);
      if (rsp_valid && rsp_k < 0) begin
        rsp_k = k; rdata = rsp_rdata; err = rsp_err;
      end
      if (rsp_k >= 0 && k >= rsp_k + 2) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_memread, mem_memwrite} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {req_ready, rsp_valid, rsp_err, mem_memread, mem_memwrite});
    else pass_cnt++;
    total++;
    if ({mem_addr, mem_write_data, rsp_rdata, mem_sign_mask} !== 100'd0)
      $display("FAIL reset_data got %h/%h/%h/%h want all 0", mem_addr, mem_write_data, rsp_rdata, mem_sign_mask);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
    else pass_cnt++;
  endtask

  task automatic test_load_word();
    int k, rd_n, wr_n; logic [31:0] rd, a_s, wd_s; logic er; logic [3:0] m_s;
    mem_read_data = 32'hDEADBEEF;
    run_access(1'b0, 32'h1004, 32'h0, 2'b10, 1'b0, k, rd, er, rd_n, wr_n, a_s, wd_s, m_s);
    total++;
    if (k !== 4) $display("FAIL lw_latency got %0d want 4", k); else pass_cnt++;
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_data got %h err %b want deadbeef err 0", rd, er);
    else pass_cnt++;
    total++;
    if (rd_n !== 1 || wr_n !== 0) $display("FAIL lw_strobes got rd %0d wr %0d want 1 0", rd_n, wr_n);
    else pass_cnt++;
    total++;
    if (a_s !== 32'h1004 || m_s !== 4'b0111) $display("FAIL lw_issue got %h %b want 00001004 0111", a_s, m_s);
    else pass_cnt++;
  endtask

  task automatic test_signed_byte();
    int k, rd_n, wr_n; logic [31:0] rd, a_s, wd_s; logic er; logic [3:0] m_s;
    mem_read_data = 32'hFFFFFF80;
    run_access(1'b0, 32'h1003, 32'h0, 2'b00, 1'b1, k, rd, er, rd_n, wr_n, a_s, wd_s, m_s);
    total++;
    if (m_s !== 4'b1001 || a_s !== 32'h1003) $display("FAIL lb_issue got %b %h want 1001 00001003", m_s, a_s);
    else pass_cnt++;
    total++;
    if (k !== 4 || rd !== 32'hFFFFFF80 || er !== 1'b0)
      $display("FAIL lb_rsp got k %0d %h err %b want 4 ffffff80 0", k, rd, er);
    else pass_cnt++;
  endtask

  task automatic test_store();
    int k, rd_n, wr_n; logic [31:0] rd, a_s, wd_s; logic er; logic [3:0] m_s;
    mem_read_data = 32'h12345678;
    run_access(1'b1, 32'h2000, 32'h000000A5, 2'b10, 1'b0, k, rd, er, rd_n, wr_n, a_s, wd_s, m_s);
    total++;
    if (wr_n !== 1 || rd_n !== 0) $display("FAIL sw_strobes got wr %0d rd %0d want 1 0", wr_n, rd_n);
    else pass_cnt++;
    total++;
    if (wd_s !== 32'hA5 || m_s !== 4'b0111 || a_s !== 32'h2000)
      $display("FAIL sw_issue got %h %b %h want 000000a5 0111 00002000", wd_s, m_s, a_s);
    else pass_cnt++;
    total++;
    if (k !== 4 || rd !== 32'd0 || er !== 1'b0) $display("FAIL sw_rsp got k %0d %h err %b want 4 0 0", k, rd, er);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int k, rd_n, wr_n; logic [31:0] rd, a_s, wd_s; logic er; logic [3:0] m_s;
    model_en = 1'b0;
    mem_read_data = 32'hCAFEF00D;
    run_access(1'b0, 32'h1008, 32'h0, 2'b10, 1'b0, k, rd, er, rd_n, wr_n, a_s, wd_s, m_s);
    model_en = 1'b1;
    total++;
    if (k !== 16) $display("FAIL tmo_latency got %0d want 16", k); else pass_cnt++;
    total++;
    if (er !== 1'b1 || rd !== 32'd0) $display("FAIL tmo_rsp got err %b %h want 1 0", er, rd);
    else pass_cnt++;
    total++;
    if (rd_n !== 1) $display("FAIL tmo_strobes got %0d want 1", rd_n); else pass_cnt++;
  endtask

  task automatic test_reserved_size();
    int k, rd_n, wr_n; logic [31:0] rd, a_s, wd_s; logic er; logic [3:0] m_s;
    run_access(1'b0, 32'h1000, 32'h0, 2'b11, 1'b0, k, rd, er, rd_n, wr_n, a_s, wd_s, m_s);
    total++;
    if (rd_n + wr_n !== 0) $display("FAIL rsv_strobes got %0d want 0", rd_n + wr_n); else pass_cnt++;
    total++;
    if (k !== 1 || er !== 1'b1 || rd !== 32'd0) $display("FAIL rsv_rsp got k %0d err %b %h want 1 1 0", k, er, rd);
    else pass_cnt++;
  endtask

  task automatic test_misalign();
    int k, rd_n, wr_n; logic [31:0] rd, a_s, wd_s; logic er; logic [3:0] m_s;
    mem_read_data = 32'h0000BEEF;
    run_access(1'b0, 32'h1001, 32'h0, 2'b01, 1'b0, k, rd, er, rd_n, wr_n, a_s, wd_s, m_s);
`ifdef LSU_MISALIGN_TRAP_EN
    total++;
    if (rd_n !== 0) $display("FAIL mis_strobes got %0d want 0", rd_n); else pass_cnt++;
    total++;
    if (k !== 1 || er !== 1'b1) $display("FAIL mis_rsp got k %0d err %b want 1 1", k, er); else pass_cnt++;
`else
    total++;
    if (rd_n !== 1 || a_s !== 32'h1001 || m_s !== 4'b0011)
      $display("FAIL mis_strobes got %0d %h %b want 1 00001001 0011", rd_n, a_s, m_s);
    else pass_cnt++;
    total++;
    if (k !== 4 || er !== 1'b0 || rd !== 32'h0000BEEF)
      $display("FAIL mis_rsp got k %0d err %b %h want 4 0 0000beef", k, er, rd);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    int w;
    int seen_rsp;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    mem_read_data = 32'h55AA55AA;
    req_write = 1'b0; req_addr = 32'h100C; req_size = 2'b10; req_signed = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    tb_hold = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({req_ready, rsp_valid, rsp_err, mem_memread, mem_memwrite, mem_addr, rsp_rdata, mem_sign_mask} !== 73'd0)
      $display("FAIL midrst_outputs got %b %b %h %h want all 0", req_ready, rsp_valid, mem_addr, rsp_rdata);
    else pass_cnt++;
    seen_rsp = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b0) $display("FAIL midrst_ready_held cycle %0d got %b want 0", i, req_ready);
      else pass_cnt++;
      seen_rsp += int'(rsp_valid);
    end
    tb_hold = 1'b0;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || seen_rsp !== 0)
      $display("FAIL midrst_release got ready %b rsp %0d want 1 0", req_ready, seen_rsp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int k, rd_n, wr_n; logic [31:0] rd, a_s, wd_s; logic er; logic [3:0] m_s;
    mem_read_data = 32'h0BADF00D;
    run_access(1'b0, 32'h1010, 32'h0, 2'b10, 1'b0, k, rd, er, rd_n, wr_n, a_s, wd_s, m_s);
    mem_read_data = 32'h00C0FFEE;
    run_access(1'b0, 32'h1014, 32'h0, 2'b10, 1'b0, k, rd, er, rd_n, wr_n, a_s, wd_s, m_s);
    total++;
    if (k !== 4 || rd !== 32'h00C0FFEE || rd_n !== 1 || a_s !== 32'h1014)
      $display("FAIL b2b_second got k %0d %h rd %0d %h want 4 00c0ffee 1 00001014", k, rd, rd_n, a_s);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_signed_byte();
    test_store();
    test_timeout();
    test_reserved_size();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
